// File: rtl/peltier_regulator_pkg.sv
// Shared types and constants for the peltier cold-finger regulator.
// Telemetry state is only reachable when PELTIER_REG_TELEMETRY_EN is defined.
package peltier_regulator_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DATA = 3'd3,
    S_UPDATE    = 3'd4,
    S_TELEM     = 3'd5,
    S_FAULT     = 3'd6
  } state_t;

  localparam int         PERIOD_CYCLES_DEF  = 1000000;
  localparam int         TIMEOUT_CYCLES_DEF = 65535;
  localparam logic [3:0] TELEM_HDR          = 4'hA;

  // One regulation step with a symmetric dead band; 9-bit math keeps the
  // result from wrapping at either end.
  function automatic logic [7:0] step_duty(
    input logic [7:0]         duty,
    input logic signed [10:0] err,
    input int                 hyst,
    input int                 step,
    input logic [7:0]         duty_max
  );
    logic [8:0]         up;
    logic [8:0]         dn;
    logic signed [10:0] band;
    logic [7:0]         result;
    band   = 11'(hyst);
    up     = {1'b0, duty} + 9'(step);
    dn     = {1'b0, duty} - 9'(step);
    result = duty;
    if (err > band)
      result = (up > {1'b0, duty_max}) ? duty_max : up[7:0];
    else if (err < -band)
      result = dn[8] ? 8'h00 : dn[7:0];
    return result;
  endfunction

endpackage

// File: rtl/peltier_regulator.sv
// Cold-finger temperature loop: periodic MCP3008 conversion, dead-band duty stepping.
// Optional telemetry handshake enabled by defining PELTIER_REG_TELEMETRY_EN.
//
// state     | meaning
// IDLE      | waiting for the period tick
// START     | one-cycle conversion start pulse, arm timeout
// WAIT_BUSY | waiting for the interface to report busy
// WAIT_DATA | waiting for a valid result; accept it when it arrives
// UPDATE    | step duty from the new sample, pulse sample_strb
// TELEM     | hold tx_req until tx_mux accepts
// FAULT     | handshake timed out; duty forced to 0 until enable drops
module peltier_regulator
  import peltier_regulator_pkg::*;
#(
  parameter int         PERIOD_CYCLES  = PERIOD_CYCLES_DEF,
  parameter int         TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int         HYST           = 4,
  parameter int         STEP           = 2,
  parameter logic [7:0] DUTY_MAX       = 8'hC0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [9:0]  setpoint,
  output logic [7:0]  duty,
  output logic        fault,
  output logic [9:0]  last_sample,
  output logic        sample_strb,
  output logic        mcp_sample,
  input  logic        mcp_busy,
  input  logic        mcp_avail,
  input  logic [9:0]  mcp_data,
  output logic        mcp_accept,
  output logic        tx_req,
  output logic [15:0] tx_data,
  input  logic        tx_accept
);

  localparam int PW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t             state;
  state_t             state_next;
  logic [PW-1:0]      period_cnt;
  logic [TW-1:0]      tmr;
  logic               tick;
  logic               tmr_zero;
  logic               abort;
  logic [9:0]         sample_q;
  logic signed [10:0] err;

  assign tick     = enable && (period_cnt == PW'(PERIOD_CYCLES - 1));
  assign tmr_zero = (tmr == '0);
  assign err      = 11'({1'b0, sample_q}) - 11'({1'b0, setpoint});

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:      if (tick) state_next = S_START;
      S_START:     state_next = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (mcp_busy)      state_next = S_WAIT_DATA;
        else if (tmr_zero) state_next = S_FAULT;
      end
      // A result arriving on the expiry cycle is still taken.
      S_WAIT_DATA: begin
        if (mcp_avail)     state_next = (abort || !enable) ? S_IDLE : S_UPDATE;
        else if (tmr_zero) state_next = S_FAULT;
      end
      S_UPDATE: begin
`ifdef PELTIER_REG_TELEMETRY_EN
        state_next = enable ? S_TELEM : S_IDLE;
`else
        state_next = S_IDLE;
`endif
      end
      S_TELEM:     if (!enable || tx_accept) state_next = S_IDLE;
      S_FAULT:     if (!enable) state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  always_comb begin
    mcp_sample = (state == S_START);
    mcp_accept = (state == S_WAIT_DATA) && mcp_avail;
    fault      = (state == S_FAULT);
`ifdef PELTIER_REG_TELEMETRY_EN
    tx_req     = (state == S_TELEM);
    tx_data    = {TELEM_HDR, 2'b00, last_sample};
`else
    tx_req     = 1'b0;
    tx_data    = 16'h0000;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !enable)                       period_cnt <= '0;
    else if (period_cnt == PW'(PERIOD_CYCLES - 1)) period_cnt <= '0;
    else                                          period_cnt <= period_cnt + 1'b1;
  end

  // Timeout is re-armed for each of the two waits.
  always_ff @(posedge clk) begin
    if (!rst_n)
      tmr <= '0;
    else if (state == S_START || (state == S_WAIT_BUSY && mcp_busy))
      tmr <= TW'(TIMEOUT_CYCLES - 1);
    else if (!tmr_zero && (state == S_WAIT_BUSY || state == S_WAIT_DATA))
      tmr <= tmr - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || state == S_IDLE) abort <= 1'b0;
    else if (!enable)              abort <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      duty        <= 8'h00;
      last_sample <= 10'h000;
      sample_strb <= 1'b0;
      sample_q    <= 10'h000;
    end else begin
      sample_strb <= 1'b0;
      if (state == S_WAIT_DATA && mcp_avail) sample_q <= mcp_data;
      if (!enable || state_next == S_FAULT) begin
        duty <= 8'h00;
      end else if (state == S_UPDATE) begin
        duty        <= step_duty(duty, err, HYST, STEP, DUTY_MAX);
        last_sample <= sample_q;
        sample_strb <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_peltier_regulator.sv
// Directed bench for peltier_regulator with a behavioural MCP3008 interface model.
// Telemetry checks are compiled in when PELTIER_REG_TELEMETRY_EN is defined.
module tb_peltier_regulator;

  logic        clk = 1'b0;
  logic        rst_n, enable;
  logic [9:0]  setpoint;
  logic [7:0]  duty;
  logic        fault;
  logic [9:0]  last_sample;
  logic        sample_strb, mcp_sample, mcp_busy, mcp_avail, mcp_accept;
  logic [9:0]  mcp_data;
  logic        tx_req, tx_accept;
  logic [15:0] tx_data;

  int tests = 0;
  int fails = 0;
  int acc_cnt = 0, strb_cnt = 0, txreq_cnt = 0;

  logic [9:0] model_data = 10'h000;
  bit         model_respond = 1'b1;
  int         busy_lat = 2, conv_lat = 3;

  always #5 clk = ~clk;

  peltier_regulator #(
    .PERIOD_CYCLES(20), .TIMEOUT_CYCLES(30), .HYST(4), .STEP(2), .DUTY_MAX(8'hC0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .setpoint(setpoint),
    .duty(duty), .fault(fault), .last_sample(last_sample), .sample_strb(sample_strb),
    .mcp_sample(mcp_sample), .mcp_busy(mcp_busy), .mcp_avail(mcp_avail),
    .mcp_data(mcp_data), .mcp_accept(mcp_accept),
    .tx_req(tx_req), .tx_data(tx_data), .tx_accept(tx_accept)
  );

  // MCP3008 interface model: busy after busy_lat, result after conv_lat more.
  initial begin
    mcp_busy = 1'b0; mcp_avail = 1'b0; mcp_data = 10'h000;
    forever begin
      @(negedge clk);
      if (mcp_sample && model_respond) begin
        repeat (busy_lat) @(negedge clk);
        mcp_busy = 1'b1;
        repeat (conv_lat) @(negedge clk);
        mcp_busy = 1'b0; mcp_avail = 1'b1; mcp_data = model_data;
        for (int k = 0; k < 200; k++) begin
          #1;
          if (mcp_accept) break;
          @(negedge clk);
        end
        @(negedge clk);
        mcp_avail = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (mcp_accept)  acc_cnt++;
    if (sample_strb) strb_cnt++;
    if (tx_req)      txreq_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_strb(input string name);
    int n = 0;
    @(negedge clk);
    while (!sample_strb && n < 100) begin @(negedge clk); n++; end
    if (!sample_strb) begin
      tests++; fails++;
      $display("FAIL %s: sample_strb not seen within 100 cycles", name);
    end
  endtask

  typedef struct {
    logic [9:0] sp;
    logic [9:0] data;
    logic [7:0] exp_duty;
  } vec_t;

  vec_t vecs[10];
  logic [7:0] exp_d;
  int nwait;
  int acc0, strb0;

  initial begin
    vecs[0] = '{10'h200, 10'h210, 8'h02};
    vecs[1] = '{10'h200, 10'h210, 8'h04};
    vecs[2] = '{10'h200, 10'h204, 8'h04};
    vecs[3] = '{10'h200, 10'h1FC, 8'h04};
    vecs[4] = '{10'h200, 10'h205, 8'h06};
    vecs[5] = '{10'h200, 10'h1FB, 8'h04};
    vecs[6] = '{10'h200, 10'h1F0, 8'h02};
    vecs[7] = '{10'h3FF, 10'h000, 8'h00};
    vecs[8] = '{10'h3FF, 10'h000, 8'h00};
    vecs[9] = '{10'h000, 10'h3FF, 8'h02};

    rst_n = 1'b0; enable = 1'b0; setpoint = 10'h200; tx_accept = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_duty", duty, 0);
    check("rst_fault", fault, 0);
    check("rst_last_sample", last_sample, 0);
    check("rst_sample_strb", sample_strb, 0);
    check("rst_mcp_sample", mcp_sample, 0);
    check("rst_mcp_accept", mcp_accept, 0);
    check("rst_tx_req", tx_req, 0);
    rst_n = 1'b1; enable = 1'b1;

    for (int i = 0; i < 10; i++) begin
      setpoint   = vecs[i].sp;
      model_data = vecs[i].data;
      wait_strb($sformatf("vec%0d_strb", i));
      check($sformatf("vec%0d_duty", i), duty, vecs[i].exp_duty);
      check($sformatf("vec%0d_last_sample", i), last_sample, vecs[i].data);
      @(negedge clk);
      check($sformatf("vec%0d_strb_width", i), sample_strb, 0);
    end

    // Saturate up from 2 to the 0xC0 ceiling and hold there.
    setpoint = 10'h200; model_data = 10'h210; exp_d = 8'h02;
    for (int i = 0; i < 100; i++) begin
      exp_d = (exp_d >= 8'hBE) ? 8'hC0 : exp_d + 8'h02;
      wait_strb("satup_strb");
      check($sformatf("satup%0d_duty", i), duty, exp_d);
    end

    // Disable while in WAIT_DATA.
    conv_lat = 10;
    nwait = 0;
    while (!mcp_busy && nwait < 100) begin @(negedge clk); nwait++; end
    check("middis_busy_seen", mcp_busy, 1);
    @(negedge clk);
    acc0 = acc_cnt; strb0 = strb_cnt;
    enable = 1'b0;
    @(negedge clk);
    check("middis_duty_next", duty, 0);
    repeat (30) @(negedge clk);
    check("middis_accepts", acc_cnt - acc0, 1);
    check("middis_no_strb", strb_cnt - strb0, 0);
    check("middis_duty", duty, 0);
    check("middis_fault", fault, 0);
    conv_lat = 3;
    enable = 1'b1;
    model_data = 10'h210;
    wait_strb("reen_strb");
    check("reen_duty", duty, 2);

    // Handshake timeout: interface never goes busy.
    model_respond = 1'b0;
    nwait = 0;
    @(negedge clk);
    while (!mcp_sample && nwait < 100) begin @(negedge clk); nwait++; end
    check("tmo_start_seen", mcp_sample, 1);
    repeat (30) @(negedge clk);
    check("tmo_fault_before", fault, 0);
    @(negedge clk);
    check("tmo_fault", fault, 1);
    check("tmo_duty", duty, 0);
    repeat (50) @(negedge clk);
    check("tmo_fault_sticky", fault, 1);
    check("tmo_no_start", mcp_sample, 0);
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    check("tmo_fault_cleared", fault, 0);
    model_respond = 1'b1;
    wait_strb("recover_strb");
    check("recover_duty", duty, 2);

`ifdef PELTIER_REG_TELEMETRY_EN
    nwait = 0;
    while (!tx_req && nwait < 20) begin @(negedge clk); nwait++; end
    for (int i = 0; i < 5; i++) begin
      check($sformatf("tel_req_hold%0d", i), tx_req, 1);
      check($sformatf("tel_data%0d", i), tx_data, 16'hA000 | 16'h0210);
      if (i < 4) @(negedge clk);
    end
    tx_accept = 1'b1;
    @(negedge clk);
    tx_accept = 1'b0;
    check("tel_req_drop", tx_req, 0);
    model_data = 10'h210;
    wait_strb("tel_next_strb");
    check("tel_next_duty", duty, 4);
`else
    check("notel_req_never", txreq_cnt, 0);
    check("notel_data", tx_data, 0);
`endif

    // Reset mid-run returns outputs to reset values.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mrst_duty", duty, 0);
    check("mrst_last_sample", last_sample, 0);
    check("mrst_fault", fault, 0);
    check("mrst_strb", sample_strb, 0);
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
